// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> big-endian imem words, holds CPU until loaded.
// Optional opcode screening of each word is enabled by defining OPCODE_CHECK_EN.
module imem_loader #(
    parameter int         ADDR_WIDTH = 12,
    parameter int         BASE_ADDR  = 0,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  clear,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code
);

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, WORD, CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           word_q, word_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [7:0]            csum_q, csum_d;
    logic [31:0]           asm_q, asm_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [1:0]            code_q, code_d;

    logic        accept;
    logic [31:0] word_full;
    logic [15:0] cnt_full;
    logic [31:0] addr_sum;
    logic        op_ok;

    assign in_ready   = (state_q != ERR);
    assign accept     = in_valid && in_ready;
    assign word_full  = {asm_q[23:0], in_data};
    assign cnt_full   = {count_q[15:8], in_data};
    assign addr_sum   = 32'(BASE_ADDR) + {16'd0, word_q};

`ifdef OPCODE_CHECK_EN
    function automatic logic op_legal(input logic [4:0] op);
        unique case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
            5'd6, 5'd7, 5'd8, 5'd21, 5'd22: op_legal = 1'b1;
            default:                         op_legal = 1'b0;
        endcase
    endfunction
    assign op_ok = op_legal(word_full[31:27]);
`else
    assign op_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        bidx_d  = bidx_q;
        csum_d  = csum_q;
        asm_d   = asm_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept && in_data == MAGIC) begin
                    state_d = CNT_HI;
                    csum_d  = 8'd0;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    count_d[15:8] = in_data;
                    state_d       = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    count_d = cnt_full;
                    bidx_d  = 2'd0;
                    word_d  = 16'd0;
                    if ({1'b0, cnt_full} > CAP) begin
                        state_d = ERR;
                        code_d  = 2'd2;
                    end else if (cnt_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = WORD;
                    end
                end
            end
            WORD: begin
                if (accept) begin
                    asm_d  = word_full;
                    csum_d = csum_q ^ in_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Bad opcode: drop the word and stop in the write cycle
                        if (!op_ok) begin
                            state_d = ERR;
                            code_d  = 2'd3;
                        end else begin
                            wren_d = 1'b1;
                            addr_d = addr_sum[ADDR_WIDTH-1:0];
                            data_d = word_full;
                            word_d = word_q + 16'd1;
                            if (word_q == count_q - 16'd1)
                                state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                        code_d  = 2'd1;
                    end
                end
            end
            ERR: begin
                if (clear) begin
                    state_d = IDLE;
                    code_d  = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            word_q  <= '0;
            bidx_q  <= '0;
            csum_q  <= '0;
            asm_q   <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            bidx_q  <= bidx_d;
            csum_q  <= csum_d;
            asm_q   <= asm_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            code_q  <= code_d;
        end
    end

    assign imem_wren  = wren_q;
    assign imem_addr  = addr_q;
    assign imem_data  = data_q;
    assign cpu_hold   = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign error_code = code_q;

endmodule
